// File: rtl/kernel_kcore_write_back_start_sync_if.sv
// Handshake bundle between the start/done token FIFOs, the write_back process and the start-sync controller.
// master = controller side, slave = FIFO/process environment side.
interface kernel_kcore_write_back_start_sync_if #(
  parameter int DATA_WIDTH = 1
);
  // Handshakes: a token moves on a start-FIFO pop when ap_start & ap_ready are both high at a
  // rising edge; a completion moves when ap_done & ap_continue (== done_write) are high at an edge.
  logic                  start_empty_n;
  logic                  start_read;
  logic [DATA_WIDTH-1:0] start_dout;
  logic                  ap_start;
  logic                  ap_ready;
  logic                  ap_done;
  logic                  ap_idle;
  logic                  ap_continue;
  logic                  done_full_n;
  logic                  done_write;
  logic [DATA_WIDTH-1:0] done_din;

  modport master (
    input  start_empty_n, start_dout, ap_ready, ap_done, ap_idle, done_full_n,
    output start_read, ap_start, ap_continue, done_write, done_din
  );

  modport slave (
    output start_empty_n, start_dout, ap_ready, ap_done, ap_idle, done_full_n,
    input  start_read, ap_start, ap_continue, done_write, done_din
  );
endinterface

// File: rtl/kernel_kcore_write_back_start_sync.sv
// Start-token consumer for write_back: launches tasks, queues their tags, returns tags on completion.
// Optional KCORE_START_SYNC_PERF_EN adds perf_tasks / perf_stall counters.
module kernel_kcore_write_back_start_sync #(
  parameter int DATA_WIDTH   = 1,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic clk,
  input  logic reset,
  kernel_kcore_write_back_start_sync_if.master bus,
  output logic busy,
  output logic proto_err
`ifdef KCORE_START_SYNC_PERF_EN
  ,
  output logic [31:0] perf_tasks,
  output logic [31:0] perf_stall
`endif
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_INFLIGHT);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_INFLIGHT - 1);

  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      inflight_nxt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] tag_mem [MAX_INFLIGHT];
  logic                  busy_q;
  logic                  err_q;
  logic                  launch;
  logic                  complete;
  logic                  err_set;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Full uses the registered count, so a completion never frees a slot in the same cycle.
  always_comb begin
    bus.ap_start    = bus.start_empty_n & (inflight < MAX_CNT) & ~reset;
    launch          = bus.ap_start & bus.ap_ready;
    bus.start_read  = launch;
    complete        = bus.ap_done & bus.done_full_n & (inflight != '0) & ~reset;
    bus.ap_continue = complete;
    bus.done_write  = complete;
    bus.done_din    = tag_mem[rd_ptr];
    err_set         = (bus.ap_done & (inflight == '0))
                    | (bus.ap_idle & (inflight != '0) & ~bus.ap_done)
                    | (bus.ap_ready & ~bus.ap_start);
  end

  always_comb begin
    inflight_nxt = inflight;
    if (launch && !complete)      inflight_nxt = inflight + CNT_W'(1);
    else if (!launch && complete) inflight_nxt = inflight - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (launch)   wr_ptr <= ptr_inc(wr_ptr);
      if (complete) rd_ptr <= ptr_inc(rd_ptr);
      inflight <= inflight_nxt;
      busy_q   <= (inflight_nxt != '0);
      err_q    <= err_q | err_set;
    end
  end

  // Tag storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (launch) tag_mem[wr_ptr] <= bus.start_dout;
  end

  assign busy      = busy_q & ~reset;
  assign proto_err = err_q & ~reset;

`ifdef KCORE_START_SYNC_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_tasks <= '0;
      perf_stall <= '0;
    end else begin
      if (complete)                        perf_tasks <= perf_tasks + 32'd1;
      if (bus.ap_done && !bus.done_full_n) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kernel_kcore_write_back_start_sync.sv
// Bench for kernel_kcore_write_back_start_sync: directed scenarios plus random traffic against a queue model.
module tb_kernel_kcore_write_back_start_sync;
  localparam int DW  = 1;
  localparam int MAX = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  kernel_kcore_write_back_start_sync_if #(.DATA_WIDTH(DW)) bus ();
  logic busy;
  logic proto_err;
`ifdef KCORE_START_SYNC_PERF_EN
  logic [31:0] perf_tasks;
  logic [31:0] perf_stall;
`endif

  kernel_kcore_write_back_start_sync #(.DATA_WIDTH(DW), .MAX_INFLIGHT(MAX)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .busy      (busy),
    .proto_err (proto_err)
`ifdef KCORE_START_SYNC_PERF_EN
    ,
    .perf_tasks(perf_tasks),
    .perf_stall(perf_stall)
`endif
  );

  // process-side stimulus knobs
  bit rdy_en;
  bit f_rdy;
  bit f_idle;
  assign bus.ap_ready = f_rdy | (bus.ap_start & rdy_en);

  // scoreboard / reference state
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] tok_q[$];
  int proc_pending = 0;
  bit exp_busy = 0;
  bit exp_err  = 0;
  logic [31:0] exp_tasks = 0;
  logic [31:0] exp_stall = 0;
  int reads_seen  = 0;
  int writes_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check 1ns later, update the model after the edge.
  task automatic cycle(input bit rdy, input bit fin, input bit full_n, input bit rst_in);
    bit e_start, e_ready, e_read, e_comp, e_err_set, d_read, d_acc, d_cont, stall;
    logic [DW-1:0] head;
    @(negedge clk);
    reset           = rst_in;
    rdy_en          = rdy;
    bus.done_full_n = full_n;
    if (!bus.ap_done && fin && proc_pending > 0) bus.ap_done = 1'b1;
    bus.ap_idle       = f_idle | (proc_pending == 0 && !bus.ap_done);
    bus.start_empty_n = (tok_q.size() != 0);
    head              = (tok_q.size() != 0) ? tok_q[0] : '0;
    bus.start_dout    = head;
    #1;
    e_start = !rst_in && tok_q.size() != 0 && exp_q.size() < MAX;
    e_ready = f_rdy | (e_start & rdy);
    e_read  = e_start & e_ready;
    e_comp  = !rst_in && bus.ap_done && full_n && exp_q.size() != 0;
    check("ap_start",    32'(bus.ap_start),    32'(e_start));
    check("start_read",  32'(bus.start_read),  32'(e_read));
    check("ap_continue", 32'(bus.ap_continue), 32'(e_comp));
    check("done_write",  32'(bus.done_write),  32'(e_comp));
    if (e_comp) check("done_din", 32'(bus.done_din), 32'(exp_q[0]));
    check("busy",      32'(busy),      32'(exp_busy && !rst_in));
    check("proto_err", 32'(proto_err), 32'(exp_err && !rst_in));
`ifdef KCORE_START_SYNC_PERF_EN
    if (!rst_in) begin
      check("perf_tasks", perf_tasks, exp_tasks);
      check("perf_stall", perf_stall, exp_stall);
    end
`endif
    e_err_set = (bus.ap_done && exp_q.size() == 0)
             || (bus.ap_idle && exp_q.size() != 0 && !bus.ap_done)
             || (e_ready && !e_start);
    d_read = bus.start_read;
    d_acc  = bus.ap_start & bus.ap_ready;
    d_cont = bus.ap_continue;
    stall  = bus.ap_done & !full_n;
    @(posedge clk);
    #1;
    if (d_read) begin
      void'(tok_q.pop_front());
      reads_seen++;
    end
    if (d_cont) writes_seen++;
    if (rst_in) begin
      exp_q.delete();
      exp_err      = 0;
      exp_tasks    = 0;
      exp_stall    = 0;
      proc_pending = 0;
      bus.ap_done  = 1'b0;
    end else begin
      if (e_comp) void'(exp_q.pop_front());
      if (e_read) exp_q.push_back(head);
      exp_err = exp_err | e_err_set;
      if (e_comp) exp_tasks = exp_tasks + 32'd1;
      if (stall)  exp_stall = exp_stall + 32'd1;
      if (d_acc) proc_pending++;
      if (d_cont && bus.ap_done) begin
        bus.ap_done = 1'b0;
        proc_pending--;
      end
    end
    exp_busy = (exp_q.size() != 0);
  endtask

  initial begin
    int r0, w0, sz;
    logic [31:0] s0, t0;
    reset = 1'b1;
    rdy_en = 0; f_rdy = 0; f_idle = 0;
    bus.start_empty_n = 1'b0;
    bus.start_dout    = '0;
    bus.ap_done       = 1'b0;
    bus.ap_idle       = 1'b1;
    bus.done_full_n   = 1'b1;
    cycle(1, 0, 1, 1);
    cycle(1, 0, 1, 1);

    // T1 single task
    tok_q.push_back(1'b1);
    r0 = reads_seen; w0 = writes_seen;
    cycle(1, 0, 1, 0);
    check("t1_read_once", 32'(reads_seen - r0), 32'd1);
    repeat (4) cycle(0, 0, 1, 0);
    cycle(0, 1, 1, 0);
    check("t1_write_once", 32'(writes_seen - w0), 32'd1);
    cycle(0, 0, 1, 0);

    // T2 inflight limit
    tok_q.push_back(1'b0); tok_q.push_back(1'b1); tok_q.push_back(1'b0);
    r0 = reads_seen;
    repeat (4) cycle(1, 0, 1, 0);
    check("t2_reads", 32'(reads_seen - r0), 32'd2);
    check("t2_fifo_left", 32'(tok_q.size()), 32'd1);
    cycle(1, 1, 1, 0);
    check("t2_still_two_reads", 32'(reads_seen - r0), 32'd2);
    cycle(1, 0, 1, 0);
    check("t2_third_launch", 32'(reads_seen - r0), 32'd3);

    // T3 done backpressure
    w0 = writes_seen; s0 = exp_stall; t0 = exp_tasks;
    repeat (4) cycle(0, 1, 0, 0);
    check("t3_no_write", 32'(writes_seen - w0), 32'd0);
    cycle(0, 1, 1, 0);
    check("t3_one_write", 32'(writes_seen - w0), 32'd1);
    check("t3_stall_cycles", exp_stall - s0, 32'd4);
    check("t3_tasks", exp_tasks - t0, 32'd1);
    cycle(0, 0, 1, 0);

    // T4 simultaneous launch + completion with one task in flight
    tok_q.push_back(1'b1);
    cycle(1, 1, 1, 0);
    check("t4_depth", 32'(exp_q.size()), 32'd1);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 1, 0);

    // T5 protocol errors: stray done, idle while busy, ready without start
    bus.ap_done = 1'b1;
    w0 = writes_seen;
    cycle(0, 0, 1, 0);
    bus.ap_done = 1'b0;
    repeat (3) cycle(0, 0, 1, 0);
    check("t5_not_forwarded", 32'(writes_seen - w0), 32'd0);
    cycle(0, 0, 1, 1);
    tok_q.push_back(1'b0);
    cycle(1, 0, 1, 0);
    f_idle = 1;
    cycle(0, 0, 1, 0);
    f_idle = 0;
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    f_rdy = 1;
    cycle(0, 0, 1, 0);
    f_rdy = 0;
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);

    // T6 reset mid-operation
    tok_q.push_back(1'b1); tok_q.push_back(1'b0); tok_q.push_back(1'b1);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    sz = tok_q.size();
    cycle(1, 0, 1, 1);
    check("t6_fifo_untouched", 32'(tok_q.size()), 32'(sz));
    cycle(0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0 && tok_q.size() < 4) tok_q.push_back(DW'($urandom));
      cycle(bit'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 80) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
